rgmii_tx_framer: RTL and testbench

- Gigabit Ethernet transmit framer feeding the DDR output-register stage on the RGMII TX pins.
- Accepts a byte stream of frame content (destination MAC through payload) and adds preamble and SFD.
- Pads short frames to the minimum length, appends the CRC-32 FCS, and enforces the inter-frame gap.
- Emits per-cycle rising/falling-edge nibble pairs for TXD[3:0] and TX_CTL, ready to drive the DDR output instances directly.

---
 rtl/rgmii_tx_framer_if.sv | 22 ++
 rtl/rgmii_tx_framer.sv | 168 ++++++++++++++++
 tb/tb_rgmii_tx_framer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgmii_tx_framer_if.sv
// Byte-stream handshake carrying frame content (destination MAC through payload) into the
// RGMII transmit framer.
interface rgmii_tx_framer_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;

    modport master (
        output s_data,
        output s_valid,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/rgmii_tx_framer.sv
// Gigabit RGMII transmit framer: adds preamble/SFD, zero-pads, appends CRC-32 FCS and holds off
// for the inter-frame gap. Outputs are registered nibble pairs for the DDR output cells.
module rgmii_tx_framer #(
    parameter int unsigned MIN_FRAME = 60,
    parameter int unsigned IFG_BYTES = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    rgmii_tx_framer_if.slave s_if,
    output logic [3:0]       txd_d1_o,
    output logic [3:0]       txd_d2_o,
    output logic             txctl_d1_o,
    output logic             txctl_d2_o,
    output logic             busy_o,
    output logic             underrun_o
);

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StSfd,
        StData,
        StPad,
        StFcs,
        StIfg,
        StDrain
    } state_e;

    // The IDLE exit cycle already launches the first 0x55, so PREAMBLE covers the other six.
    localparam logic [7:0]  PreLast = 8'd5;
    localparam logic [7:0]  IfgLast = 8'(IFG_BYTES - 1);
    localparam logic [11:0] MinLen  = 12'(MIN_FRAME);

    state_e      state_q, state_d;
    logic [7:0]  phase_q, phase_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  txd_q;
    logic        ctl1_q, ctl2_q, busy_q, underrun_q;

    logic [7:0]  byte_d;
    logic        en_d, er_d, underrun_d;
    logic [10:0] cnt_inc;

    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    assign cnt_inc = (byte_cnt_q == '1) ? byte_cnt_q : byte_cnt_q + 11'd1;
    assign s_if.s_ready = (state_q == StData) || (state_q == StDrain);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        byte_cnt_d = byte_cnt_q;
        crc_d      = crc_q;
        byte_d     = 8'h00;
        en_d       = 1'b0;
        er_d       = 1'b0;
        underrun_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (s_if.s_valid) begin
                    state_d    = StPreamble;
                    phase_d    = '0;
                    byte_cnt_d = '0;
                    crc_d      = '1;
                    byte_d     = 8'h55;
                    en_d       = 1'b1;
                end
            end
            StPreamble: begin
                byte_d  = 8'h55;
                en_d    = 1'b1;
                phase_d = phase_q + 8'd1;
                if (phase_q == PreLast) state_d = StSfd;
            end
            StSfd: begin
                byte_d  = 8'hD5;
                en_d    = 1'b1;
                state_d = StData;
            end
            StData: begin
                en_d = 1'b1;
                if (s_if.s_valid) begin
                    byte_d     = s_if.s_data;
                    crc_d      = crc_step(crc_q, s_if.s_data);
                    byte_cnt_d = cnt_inc;
                    if (s_if.s_last) begin
                        phase_d = '0;
                        state_d = ({1'b0, cnt_inc} < MinLen) ? StPad : StFcs;
                    end
                end else begin
                    // Starved mid-frame: poison the frame with tx_er and discard the rest.
                    er_d       = 1'b1;
                    underrun_d = 1'b1;
                    state_d    = StDrain;
                end
            end
            StPad: begin
                en_d       = 1'b1;
                crc_d      = crc_step(crc_q, 8'h00);
                byte_cnt_d = cnt_inc;
                if ({1'b0, cnt_inc} >= MinLen) begin
                    phase_d = '0;
                    state_d = StFcs;
                end
            end
            StFcs: begin
                byte_d  = ~crc_q[{phase_q[1:0], 3'b000} +: 8];
                en_d    = 1'b1;
                phase_d = phase_q + 8'd1;
                if (phase_q[1:0] == 2'd3) begin
                    phase_d = '0;
                    state_d = StIfg;
                end
            end
            StIfg: begin
                phase_d = phase_q + 8'd1;
                if (phase_q == IfgLast) state_d = StIdle;
            end
            StDrain: begin
                if (s_if.s_valid && s_if.s_last) begin
                    phase_d = '0;
                    state_d = StIfg;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            phase_q    <= '0;
            byte_cnt_q <= '0;
            crc_q      <= '1;
            txd_q      <= '0;
            ctl1_q     <= 1'b0;
            ctl2_q     <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            byte_cnt_q <= byte_cnt_d;
            crc_q      <= crc_d;
            txd_q      <= byte_d;
            ctl1_q     <= en_d;
            ctl2_q     <= en_d ^ er_d;
            busy_q     <= (state_d != StIdle);
            underrun_q <= underrun_d;
        end
    end

    assign txd_d1_o   = txd_q[3:0];
    assign txd_d2_o   = txd_q[7:4];
    assign txctl_d1_o = ctl1_q;
    assign txctl_d2_o = ctl2_q;
    assign busy_o     = busy_q;
    assign underrun_o = underrun_q;

endmodule

// File: tb/tb_rgmii_tx_framer.sv
// Bench for rgmii_tx_framer: drives random frames and compares every transmitted burst with a
// frame built directly from the Ethernet framing rules.
module tb_rgmii_tx_framer;

    typedef byte unsigned bq_t[$];

    localparam int MinFrame = 60;
    localparam int IfgBytes = 12;

    logic       clk;
    logic       rst_n;
    logic [3:0] txd_d1, txd_d2;
    logic       txctl_d1, txctl_d2, busy, underrun;

    rgmii_tx_framer_if s_if ();

    rgmii_tx_framer #(
        .MIN_FRAME(MinFrame),
        .IFG_BYTES(IfgBytes)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_if      (s_if),
        .txd_d1_o  (txd_d1),
        .txd_d2_o  (txd_d2),
        .txctl_d1_o(txctl_d1),
        .txctl_d2_o(txctl_d2),
        .busy_o    (busy),
        .underrun_o(underrun)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    byte unsigned mon_bytes[$];
    int b_start[$], b_len[$], b_first[$], b_last[$], b_errpos[$];
    int busy_fall[$];
    int und_cnt = 0;
    int und_cyc = -1;

    initial begin
        clk = 1'b0;
        forever #4 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Wire monitor: every tx_en burst is captured with its cycle span and tx_er position.
    initial begin
        bit in_burst;
        bit prev_busy;
        int cur_start, cur_first, cur_last, cur_err;
        in_burst  = 1'b0;
        prev_busy = 1'b0;
        cur_start = 0;
        cur_first = 0;
        cur_last  = 0;
        cur_err   = -1;
        forever begin
            @(negedge clk);
            if (txctl_d1) begin
                if (!in_burst) begin
                    in_burst  = 1'b1;
                    cur_start = mon_bytes.size();
                    cur_first = cyc;
                    cur_err   = -1;
                end
                if (!txctl_d2) cur_err = mon_bytes.size() - cur_start;
                mon_bytes.push_back({txd_d2, txd_d1});
                cur_last = cyc;
            end else if (in_burst) begin
                in_burst = 1'b0;
                b_start.push_back(cur_start);
                b_len.push_back(mon_bytes.size() - cur_start);
                b_first.push_back(cur_first);
                b_last.push_back(cur_last);
                b_errpos.push_back(cur_err);
            end
            if (underrun) begin
                und_cnt++;
                und_cyc = cyc;
            end
            if (prev_busy && !busy) busy_fall.push_back(cyc);
            prev_busy = busy;
        end
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input byte unsigned d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    // Expected wire image: 7x55, D5, content, zero pad to MinFrame, FCS low byte first.
    task automatic build_exp(input bq_t c, output bq_t e);
        bq_t body;
        logic [31:0] crc;
        body = c;
        while (body.size() < MinFrame) body.push_back(8'h00);
        crc = 32'hFFFF_FFFF;
        foreach (body[k]) crc = crc_upd(crc, body[k]);
        crc = ~crc;
        e.delete();
        for (int k = 0; k < 7; k++) e.push_back(8'h55);
        e.push_back(8'hD5);
        foreach (body[k]) e.push_back(body[k]);
        for (int k = 0; k < 4; k++) e.push_back(crc[8*k +: 8]);
    endtask

    task automatic check_frame(input string tag, input int bi, input bq_t c);
        bq_t e;
        int nbad;
        logic [31:0] r;
        check_eq({tag, "_present"}, bi < b_len.size(), 1);
        if (bi >= b_len.size()) return;
        build_exp(c, e);
        check_eq({tag, "_len"}, b_len[bi], e.size());
        nbad = 0;
        for (int k = 0; k < e.size() && k < b_len[bi]; k++) begin
            if (mon_bytes[b_start[bi] + k] != e[k]) nbad++;
        end
        check_eq({tag, "_bytes"}, nbad, 0);
        check_eq({tag, "_er"}, b_errpos[bi] >= 0, 0);
        r = 32'hFFFF_FFFF;
        for (int k = 8; k < b_len[bi]; k++) r = crc_upd(r, mon_bytes[b_start[bi] + k]);
        check_eq({tag, "_residue"}, r, 32'hDEBB_20E3);
    endtask

    task automatic send_frame(input bq_t f, input int drop_at, input int stop_at);
        int i;
        int g;
        bit acc;
        i = 0;
        g = 0;
        while (i < f.size() && g < 4000) begin
            s_if.s_valid = 1'b1;
            s_if.s_data  = f[i];
            s_if.s_last  = (i == f.size() - 1);
            @(negedge clk);
            acc = s_if.s_ready;
            @(posedge clk);
            #1;
            g++;
            if (acc) begin
                i++;
                if (i == stop_at) begin
                    s_if.s_data = f[i];
                    return;
                end
                if (i == drop_at) begin
                    s_if.s_valid = 1'b0;
                    s_if.s_last  = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
        end
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
        s_if.s_data  = 8'h00;
        check_eq("drv_done", i, f.size());
    endtask

    task automatic wait_bursts(input int n);
        int g;
        g = 0;
        while (b_len.size() < n && g < 4000) begin
            @(posedge clk);
            g++;
        end
        check_eq("burst_wait", b_len.size() >= n, 1);
    endtask

    task automatic rand_frame(input int n, output bq_t c);
        c.delete();
        for (int k = 0; k < n; k++) c.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        bq_t c, c2, e;
        byte unsigned arp[14];
        int bi, nb, u0, nbad, nz;
        arp = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h08, 8'h06};
        rst_n        = 1'b0;
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
        s_if.s_data  = 8'h00;
        #10;
        check_eq("rst_outs", {txd_d1, txd_d2, txctl_d1, txctl_d2, busy, underrun, s_if.s_ready}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("idle_busy", busy, 0);

        // Short ARP header padded to the minimum.
        c.delete();
        foreach (arp[k]) c.push_back(arp[k]);
        send_frame(c, -1, -1);
        wait_bursts(1);
        check_frame("arp", 0, c);
        nz = 0;
        for (int k = 22; k < 68 && k < b_len[0]; k++) begin
            if (mon_bytes[b_start[0] + k] == 8'h00) nz++;
        end
        check_eq("arp_pad_zeros", nz, 46);
        check_eq("sfd_d1", mon_bytes[b_start[0] + 7] & 8'h0F, 4'h5);
        check_eq("sfd_d2", mon_bytes[b_start[0] + 7] >> 4, 4'hD);

        // 100-byte frame: no pad; busy must drop IfgBytes cycles after the last FCS byte.
        rand_frame(100, c);
        c[0] = 8'hA5;
        nb = b_len.size();
        send_frame(c, -1, -1);
        wait_bursts(nb + 1);
        check_frame("f100", nb, c);
        check_eq("nib_a5", mon_bytes[b_start[nb] + 8], 8'hA5);
        repeat (20) @(posedge clk);
        check_eq("busy_fall", (busy_fall.size() > 0) ? busy_fall[busy_fall.size() - 1] - b_last[nb] : -1,
                 IfgBytes);

        // Back-to-back: one padded, one long.
        rand_frame($urandom_range(1, 59), c);
        rand_frame($urandom_range(60, 120), c2);
        nb = b_len.size();
        send_frame(c, -1, -1);
        send_frame(c2, -1, -1);
        wait_bursts(nb + 2);
        check_frame("b2b_a", nb, c);
        check_frame("b2b_b", nb + 1, c2);
        check_eq("b2b_gap", b_first[nb + 1] - b_last[nb] - 1, IfgBytes);

        // Underrun after content byte 20 of 64, followed by a normal frame.
        rand_frame(64, c);
        rand_frame(30, c2);
        nb = b_len.size();
        u0 = und_cnt;
        send_frame(c, 20, -1);
        send_frame(c2, -1, -1);
        wait_bursts(nb + 2);
        build_exp(c, e);
        check_eq("ab_len", b_len[nb], 29);
        nbad = 0;
        for (int k = 0; k < 28; k++) if (mon_bytes[b_start[nb] + k] != e[k]) nbad++;
        check_eq("ab_prefix", nbad, 0);
        check_eq("ab_byte", mon_bytes[b_start[nb] + 28], 8'h00);
        check_eq("ab_errpos", b_errpos[nb], 28);
        check_eq("ab_und_cnt", und_cnt - u0, 1);
        check_eq("ab_und_cyc", und_cyc, b_last[nb]);
        check_eq("ab_gap", b_first[nb + 1] - b_last[nb] - 1, 44 + IfgBytes);
        check_frame("ab_next", nb + 1, c2);

        // Randomized frames, each checked on its own.
        for (int t = 0; t < 4; t++) begin
            rand_frame($urandom_range(1, 150), c);
            nb = b_len.size();
            send_frame(c, -1, -1);
            wait_bursts(nb + 1);
            check_frame($sformatf("rnd%0d", t), nb, c);
        end

        // Reset during DATA, then a fresh frame.
        rand_frame(80, c);
        send_frame(c, -1, 10);
        check_eq("pre_rst_en", txctl_d1, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_outs", {txd_d1, txd_d2, txctl_d1, txctl_d2, busy, underrun, s_if.s_ready}, 0);
        @(posedge clk);
        #1;
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rand_frame($urandom_range(20, 90), c);
        nb = b_len.size();
        send_frame(c, -1, -1);
        wait_bursts(nb + 1);
        check_frame("post_rst", nb, c);

        repeat (20) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
